// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of the arbiter. The arbiter end uses the slave modport;
// requesters and the memory model use the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  // Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps them until
  // ackN pulses for one cycle; reqN is only sampled while the arbiter is idle, so reqN still
  // high in the cycle after ackN is a new request.
  logic              req0, we0, lock0, ack0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, lock1, ack1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy, owner;

  modport master (
    output req0, we0, lock0, addr0, wdata0,
    output req1, we1, lock1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_addr, mem_read, mem_write, mem_wdata, busy, owner
  );

  modport slave (
    input  req0, we0, lock0, addr0, wdata0,
    input  req1, we1, lock1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, ack1, rdata1,
    output mem_addr, mem_read, mem_write, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arbiter_pick2.sv
// Combinational two-way winner selection: single request, lock hold, fixed priority, round-robin.
module arb_pick2
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  input  logic lock_hold,
  input  logic owner,
  output logic winner,
  output logic valid
);
  always_comb begin
    winner = PORT_CPU;
    valid  = req0 | req1;
    if (req0 && !req1) begin
      winner = PORT_CPU;
    end else if (req1 && !req0) begin
      winner = PORT_DMA;
    end else if (req0 && req1) begin
      // A locked owner keeps the memory for exactly one more contested grant.
      if (lock_hold)             winner = owner;
      else if (FIXED_PRIO != 0)  winner = PORT_CPU;
      else                       winner = ~last_winner;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing one single-port memory between the CPU (port 0) and DMA (port 1).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus,
  output state_e         state_dbg
);
  state_e            state;
  logic              last_winner;
  logic              lock_hold;
  logic              winner;
  logic              valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  arb_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_winner (last_winner),
    .lock_hold   (lock_hold),
    .owner       (bus.owner),
    .winner      (winner),
    .valid       (valid)
  );

  assign sel_addr  = winner ? bus.addr1  : bus.addr0;
  assign sel_wdata = winner ? bus.wdata1 : bus.wdata0;
  assign sel_we    = winner ? bus.we1    : bus.we0;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.busy      <= 1'b0;
      bus.owner     <= PORT_CPU;
      last_winner   <= PORT_DMA;
      lock_hold     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_write <= sel_we;
            bus.mem_read  <= ~sel_we;
            bus.owner     <= winner;
            bus.busy      <= 1'b1;
            last_winner   <= winner;
            // Any grant consumes the hold; RESP reloads it from the new owner's lock.
            lock_hold     <= 1'b0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.mem_read) begin
            if (bus.owner) bus.rdata1 <= bus.mem_rdata;
            else           bus.rdata0 <= bus.mem_rdata;
          end
          if (bus.owner) bus.ack1 <= 1'b1;
          else           bus.ack0 <= 1'b1;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          state         <= RESP;
        end
        RESP: begin
          bus.ack0  <= 1'b0;
          bus.ack1  <= 1'b0;
          bus.busy  <= 1'b0;
          lock_hold <= bus.owner ? bus.lock1 : bus.lock0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
